sized_data_mem: RTL and testbench
=================================

// Module: sized_data_mem
// PURPOSE
//  Byte-addressed MIPS data memory with byte/half/word access (lb/lbu/lh/lhu/lw/sb/sh/sw),
//  sign/zero extension, alignment checking and a pipelined request/response interface.
//  Sits between the MEM stage and storage; replaces the fixed word-only data memory.
//  Optional post-reset clear sweep gives deterministic contents.
// PARAMETERS
//  DEPTH        1024  bytes of storage; power of two, multiple of 4
//  READ_LAT     1     request-to-response latency in cycles; legal values 1 or 2
//  CLEAR_ON_RST 1     1: zero all words after reset (sweep); 0: contents undefined
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   request present this cycle
//  req_ready  out  1   block can accept; a request is accepted when req_valid && req_ready
//  req_we     in   1   1 = store, 0 = load
//  req_size   in   2   mem_size_t: 00 byte, 01 half, 10 word; 11 is illegal
//  req_unsigned in 1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr   in   32  byte address; only [$clog2(DEPTH)-1:0] used (modulo DEPTH)
//  req_wdata  in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid out  1   one-cycle pulse per accepted request, in order
//  resp_rdata out  32  load result, extended; 0 for stores and errors
//  resp_err   out  1   misaligned or illegal size; qualified by resp_valid
// BEHAVIOUR
//  - Reset (async): resp_valid=0, resp_rdata=0, resp_err=0, pipeline cleared, in-flight dropped;
//    FSM -> CLEAR if CLEAR_ON_RST else RUN. req_ready=0 while in reset.
//  - FSM CLEAR: counter 0..DEPTH/4-1 writes word 0 each cycle; req_ready=0;
//    last index -> RUN. Takes exactly DEPTH/4 cycles after rst_n deasserts.
//  - FSM RUN: req_ready=1 every cycle (no backpressure, no response stall).
//  - Storage: DEPTH/4 words x 32 with 4 byte-write-enables; word index = addr[N-1:2].
//  - Alignment: half needs addr[0]=0, word needs addr[1:0]=0; size 11 always illegal.
//    Error request: no write, resp_err=1, resp_rdata=0.
//  - Store: byte lane = addr[1:0]; sb writes lane addr[1:0], sh lanes addr[1]*2+{0,1},
//    sw all lanes. Write commits at acceptance edge.
//  - Load: word read at acceptance edge, lane extracted and extended; resp_valid rises
//    READ_LAT cycles after acceptance edge (READ_LAT=1: next cycle).
//  - Stores also produce resp_valid (rdata=0) so every request retires exactly once.
//  - Read-after-write: load accepted cycle after a store to same word returns new data.
//  - Back-to-back requests every cycle supported; responses strictly in request order.
//  - Address wrap: addr >= DEPTH aliases to addr mod DEPTH; no error.
//  - rst_n asserted mid-operation: pending responses lost, pending store committed only if
//    its edge completed; sweep restarts from index 0 when CLEAR_ON_RST=1.
// STRUCTURE
//  - mips_mem_pkg: typedef enum logic[1:0] mem_size_t {MEM_B,MEM_H,MEM_W,MEM_BAD};
//    typedef enum fsm {ST_CLEAR,ST_RUN}; function lane_mask(size,addr[1:0]) -> 4-bit enable.
//  - Sub-module data_mem_lane_align (combinational): word + addr[1:0] + size + unsigned ->
//    extended 32-bit load data; also store-data lane replication.
//  - Top: FSM + clear counter, word array, READ_LAT-deep valid/err/rdata shift pipeline.
// TESTING
//  - Reset, CLEAR_ON_RST=1, DEPTH=1024: req_ready=0 for 256 cycles, then 1; lw @0x3FC -> 0.
//  - sw 0x8899AABB @0x10; lb @0x13 -> 0xFFFFFF88; lbu @0x13 -> 0x00000088;
//    lh @0x12 -> 0xFFFF8899; lhu @0x10 -> 0x0000AABB.
//  - sb 0x7F @0x11 over 0x8899AABB; lw @0x10 -> 0x88997FBB; lh @0x11 -> err, no write.
//  - Back-to-back sw 0x12345678 @0x20 then lw @0x20 next cycle, READ_LAT=2 ->
//    two resp_valid pulses 1 cycle apart, second rdata 0x12345678.
//  - Wrap: sw 0xCAFEF00D @0x400 (DEPTH=1024); lw @0x0 -> 0xCAFEF00D, resp_err=0.
//  - Assert rst_n low with 2 loads in flight: resp_valid stays 0; sweep restarts at index 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the sized data memory.
// Size/FSM enums, lane enable mask and alignment check.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_BAD = 2'b11
  } mem_size_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fsm_t;

  function automatic logic [3:0] lane_mask(
    mem_size_t  size,
    logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (size)
      MEM_B:   m = 4'b0001 << a;
      MEM_H:   m = a[1] ? 4'b1100 : 4'b0011;
      MEM_W:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic bad_access(
    mem_size_t  size,
    logic [1:0] a
  );
    logic e;
    e = 1'b0;
    unique case (size)
      MEM_B:   e = 1'b0;
      MEM_H:   e = a[0];
      MEM_W:   e = |a;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sized_data_mem_if.sv
// Request/response bundle between the MEM stage and data memory.
// master: drives requests; slave: the memory.
interface sized_data_mem_if;
  import mips_mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  mem_size_t   req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_lane_align.sv
// Lane extract + sign/zero extend for loads, lane replicate for stores.
// in: word, a, size, uns, wdata; out: rdata, wdata_rep.
module data_mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  mem_size_t   size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wdata_rep
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sb;
  logic        sh;

  always_comb begin
    b  = word[{a, 3'b000} +: 8];
    h  = a[1] ? word[31:16] : word[15:0];
    sb = ~uns & b[7];
    sh = ~uns & h[15];
    rdata     = '0;
    wdata_rep = '0;
    unique case (size)
      MEM_B: begin
        rdata     = {{24{sb}}, b};
        wdata_rep = {4{wdata[7:0]}};
      end
      MEM_H: begin
        rdata     = {{16{sh}}, h};
        wdata_rep = {2{wdata[15:0]}};
      end
      MEM_W: begin
        rdata     = word;
        wdata_rep = wdata;
      end
      default: begin
        rdata     = '0;
        wdata_rep = '0;
      end
    endcase
  end

endmodule

// File: rtl/sized_data_mem.sv
// Byte-addressed data memory, b/h/w access, READ_LAT pipe, clear sweep.
// Ports: clk, rst_n (async low), bus (sized_data_mem_if.slave).
module sized_data_mem
  import mips_mem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LAT     = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sized_data_mem_if.slave   bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WORDS = DEPTH / 4;
  localparam int IW    = AW - 2;
  localparam fsm_t RST_ST =
    (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

  fsm_t          state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic          clr_we;

  logic [31:0]   mem_q [WORDS];

  logic          acc;
  logic          err;
  logic [AW-1:0] addr;
  logic [IW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [31:0]   ld_data;
  logic [31:0]   wrep;
  logic [3:0]    wmask;

  logic [READ_LAT-1:0]       v_q, v_d;
  logic [READ_LAT-1:0]       e_q, e_d;
  logic [READ_LAT-1:0][31:0] d_q, d_d;

  wire unused_addr = ^bus.req_addr[31:AW];

  // rst_n gate keeps ready low during reset even when no sweep
  assign bus.req_ready = rst_n & (state_q == ST_RUN);

  assign acc  = bus.req_valid & bus.req_ready;
  assign addr = bus.req_addr[AW-1:0];
  assign widx = addr[AW-1:2];
  assign lane = addr[1:0];
  assign err  = bad_access(bus.req_size, lane);
  assign word = mem_q[widx];

  data_mem_lane_align u_align (
    .word      (word),
    .a         (lane),
    .size      (bus.req_size),
    .uns       (bus.req_unsigned),
    .wdata     (bus.req_wdata),
    .rdata     (ld_data),
    .wdata_rep (wrep)
  );

  assign wmask = (acc & bus.req_we & ~err)
               ? lane_mask(bus.req_size, lane)
               : 4'b0000;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IW'(WORDS - 1))
          state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_ST;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // storage has no reset; the sweep provides known contents
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (wmask[i])
          mem_q[widx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end

  always_comb begin
    v_d    = v_q;
    e_d    = e_q;
    d_d    = d_q;
    v_d[0] = acc;
    e_d[0] = acc & err;
    d_d[0] = (acc & ~bus.req_we & ~err)
           ? ld_data : 32'd0;
    for (int i = 1; i < READ_LAT; i++) begin
      v_d[i] = v_q[i-1];
      e_d[i] = e_q[i-1];
      d_d[i] = d_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      e_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      e_q <= e_d;
      d_q <= d_d;
    end
  end

  assign bus.resp_valid = v_q[READ_LAT-1];
  assign bus.resp_err   = e_q[READ_LAT-1];
  assign bus.resp_rdata = d_q[READ_LAT-1];

endmodule

// File: tb/tb_sized_data_mem.sv
// Directed bench: READ_LAT=1 and READ_LAT=2 instances, same stimulus.
// Checks sweep, extension, lanes, errors, RAW, wrap, mid-op reset.
module tb_sized_data_mem;
  import mips_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  sized_data_mem_if b1();
  sized_data_mem_if b2();

  sized_data_mem #(
    .DEPTH(1024), .READ_LAT(1), .CLEAR_ON_RST(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  sized_data_mem #(
    .DEPTH(1024), .READ_LAT(2), .CLEAR_ON_RST(1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic        we,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    b1.req_valid    = v;
    b1.req_we       = we;
    b1.req_size     = mem_size_t'(sz);
    b1.req_unsigned = uns;
    b1.req_addr     = a;
    b1.req_wdata    = wd;
    b2.req_valid    = v;
    b2.req_we       = we;
    b2.req_size     = mem_size_t'(sz);
    b2.req_unsigned = uns;
    b2.req_addr     = a;
    b2.req_wdata    = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
  endtask

  // single request; both latencies checked on their own cycle
  task automatic do_req(
    input string       tag,
    input logic        we,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] ed,
    input logic        ee
  );
    drive(1'b1, we, sz, uns, a, wd);
    @(posedge clk); #1;
    idle();
    chk({tag, ".v1"}, 32'(b1.resp_valid), 32'd1);
    chk({tag, ".d1"}, b1.resp_rdata, ed);
    chk({tag, ".e1"}, 32'(b1.resp_err), 32'(ee));
    chk({tag, ".v2early"}, 32'(b2.resp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v1drop"}, 32'(b1.resp_valid), 32'd0);
    chk({tag, ".v2"}, 32'(b2.resp_valid), 32'd1);
    chk({tag, ".d2"}, b2.resp_rdata, ed);
    chk({tag, ".e2"}, 32'(b2.resp_err), 32'(ee));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!b1.req_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".sweep_cycles"}, 32'(n), 32'd256);
    chk({tag, ".ready2"}, 32'(b2.req_ready), 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready1", 32'(b1.req_ready), 32'd0);
    chk("rst.ready2", 32'(b2.req_ready), 32'd0);
    chk("rst.v1", 32'(b1.resp_valid), 32'd0);
    chk("rst.d1", b1.resp_rdata, 32'd0);
    chk("rst.e2", 32'(b2.resp_err), 32'd0);
    rst_n = 1'b1;
    wait_ready("init");

    do_req("lw3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 32'd0, 1'b0);
    do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 32'd0, 1'b0);
    do_req("lb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'hFFFFFF88, 1'b0);
    do_req("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h00000088, 1'b0);
    do_req("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFF8899, 1'b0);
    do_req("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'h0000AABB, 1'b0);
    do_req("lb10", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'hFFFFFFBB, 1'b0);
    do_req("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, 32'd0, 1'b0);
    do_req("lw10a", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h88997FBB, 1'b0);
    do_req("lh11", 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1);
    do_req("sw12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_req("sz11", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_req("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h88997FBB, 1'b0);
    do_req("sh16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234BEEF, 32'd0, 1'b0);
    do_req("lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'hBEEF0000, 1'b0);
    do_req("lhu16", 1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 32'h0000BEEF, 1'b0);

    // back-to-back store then load of same word
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    chk("b2b.t1.v1", 32'(b1.resp_valid), 32'd1);
    chk("b2b.t1.d1", b1.resp_rdata, 32'd0);
    chk("b2b.t1.v2", 32'(b2.resp_valid), 32'd0);
    @(posedge clk); #1;
    idle();
    chk("b2b.t2.v1", 32'(b1.resp_valid), 32'd1);
    chk("b2b.t2.d1", b1.resp_rdata, 32'h12345678);
    chk("b2b.t2.v2", 32'(b2.resp_valid), 32'd1);
    chk("b2b.t2.d2", b2.resp_rdata, 32'd0);
    @(posedge clk); #1;
    chk("b2b.t3.v1", 32'(b1.resp_valid), 32'd0);
    chk("b2b.t3.v2", 32'(b2.resp_valid), 32'd1);
    chk("b2b.t3.d2", b2.resp_rdata, 32'h12345678);
    chk("b2b.t3.e2", 32'(b2.resp_err), 32'd0);
    @(posedge clk); #1;
    chk("b2b.t4.v2", 32'(b2.resp_valid), 32'd0);

    do_req("sw400", 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'd0, 1'b0);
    do_req("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'hCAFEF00D, 1'b0);

    // two loads in flight, then async reset
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle();
    #1;
    chk("mid.v1", 32'(b1.resp_valid), 32'd0);
    chk("mid.v2", 32'(b2.resp_valid), 32'd0);
    chk("mid.d2", b2.resp_rdata, 32'd0);
    @(posedge clk); #1;
    chk("mid.v2b", 32'(b2.resp_valid), 32'd0);
    chk("mid.ready", 32'(b1.req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("mid");
    chk("mid.v2c", 32'(b2.resp_valid), 32'd0);

    do_req("clr10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0);
    do_req("clr20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'd0, 1'b0);
    do_req("clr0", 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
